kernel_loader: RTL

Upstream feeder for the convolution top level. Accepts the 3×3 kernel as a byte stream over a valid/ready handshake and assembles it into a shadow register. On a start request it commits the kernel to the stable 72-bit `kernel` output and issues a single-cycle `conv_run` pulse. It then holds `kernel` constant for a fixed run window while the next kernel may already be streamed into the shadow (double buffering).

---
 rtl/kernel_loader_pkg.sv | 13 +
 rtl/kernel_assembler.sv | 54 +++++
 rtl/kernel_loader.sv | 89 ++++++++
 3 files changed

// File: rtl/kernel_loader_pkg.sv
// Shared constants and FSM encoding for the kernel loader.
// Sized for a 3x3 kernel of byte taps.
package kernel_loader_pkg;
  localparam int NTAPS = 9;
  localparam int W = 8;
  localparam int KW = NTAPS * W;

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    RUN
  } state_t;
endpackage

// File: rtl/kernel_assembler.sv
// Collects tap bytes into the shadow kernel and flags bad frames.
// A full shadow blocks the stream until the loader takes it.
module kernel_assembler #(
  parameter int NTAPS = kernel_loader_pkg::NTAPS,
  parameter int W = kernel_loader_pkg::W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [W-1:0]       s_data,
  input  logic               s_valid,
  input  logic               s_last,
  output logic               s_ready,
  input  logic               take,
  output logic [NTAPS*W-1:0] shadow,
  output logic               shadow_valid,
  output logic               frame_err
);
  localparam int CW = $clog2(NTAPS);
  localparam logic [CW-1:0] LAST = CW'(NTAPS - 1);

  logic [CW-1:0] cnt;
  logic accept;

  assign s_ready = reset && !shadow_valid;
  assign accept = s_valid && s_ready;

  // Tap counter, shadow write and frame validation
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt <= '0;
      shadow <= '0;
      shadow_valid <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      if (take)
        shadow_valid <= 1'b0;
      if (accept) begin
        for (int i = 0; i < NTAPS; i++)
          if (cnt == CW'(i))
            shadow[i*W +: W] <= s_data;
        if (cnt == LAST && s_last) begin
          shadow_valid <= 1'b1;
          cnt <= '0;
        end else if (cnt == LAST || s_last) begin
          frame_err <= 1'b1;
          cnt <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end
endmodule

// File: rtl/kernel_loader.sv
// Double-buffered kernel feeder: commits the shadow on start,
// pulses conv_run and holds kernel for the run window.
module kernel_loader #(
  parameter int NTAPS = kernel_loader_pkg::NTAPS,
  parameter int W = kernel_loader_pkg::W,
  parameter int RUN_CYCLES = 256
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [W-1:0]       s_data,
  input  logic               s_valid,
  input  logic               s_last,
  output logic               s_ready,
  input  logic               start,
  output logic [NTAPS*W-1:0] kernel,
  output logic               conv_run,
  output logic               busy,
  output logic               frame_err
);
  import kernel_loader_pkg::*;

  localparam int TW = $clog2(RUN_CYCLES);
  localparam logic [TW-1:0] TLOAD = TW'(RUN_CYCLES - 1);

  state_t state, state_d;
  logic [TW-1:0] timer, timer_d;
  logic take;
  logic [NTAPS*W-1:0] shadow;
  logic shadow_valid;

  kernel_assembler #(
    .NTAPS(NTAPS),
    .W(W)
  ) u_asm (
    .clk(clk),
    .reset(reset),
    .s_data(s_data),
    .s_valid(s_valid),
    .s_last(s_last),
    .s_ready(s_ready),
    .take(take),
    .shadow(shadow),
    .shadow_valid(shadow_valid),
    .frame_err(frame_err)
  );

  // Next state, run timer and shadow hand-off
  always_comb begin
    state_d = state;
    timer_d = timer;
    take = 1'b0;
    unique case (state)
      IDLE: begin
        if (start && shadow_valid) begin
          take = 1'b1;
          state_d = ARM;
        end
      end
      ARM: begin
        timer_d = TLOAD;
        state_d = RUN;
      end
      RUN: begin
        timer_d = timer - 1'b1;
        if (timer_d == '0)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, timer and registered outputs
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      timer <= '0;
      kernel <= '0;
      conv_run <= 1'b0;
      busy <= 1'b0;
    end else begin
      state <= state_d;
      timer <= timer_d;
      conv_run <= (state_d == ARM);
      busy <= (state_d != IDLE);
      if (take)
        kernel <= shadow;
    end
  end
endmodule
